// File: rtl/mem_pkg.sv
// Shared opcode/state encodings and default stack bounds for the memory-stage
// stack controller.
package mem_pkg;

  localparam logic [15:0] SP_INIT_DEFAULT  = 16'h03FF;
  localparam logic [15:0] SP_LIMIT_DEFAULT = 16'h0300;

  typedef enum logic [3:0] {
    OP_NOP   = 4'd0,
    OP_LOAD  = 4'd1,
    OP_STORE = 4'd2,
    OP_PUSH  = 4'd3,
    OP_POP   = 4'd4,
    OP_CALL  = 4'd5,
    OP_RET   = 4'd6,
    OP_INT   = 4'd7,
    OP_RTI   = 4'd8
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_RD_WAIT   = 3'd1,
    ST_RET_WAIT  = 3'd2,
    ST_INT_FLAGS = 3'd3,
    ST_RTI_PC    = 3'd4,
    ST_RTI_WAIT  = 3'd5
  } state_e;

endpackage

// File: rtl/stack_ptr.sv
// Full-descending stack pointer: inc pops, dec pushes; both refused at the
// corresponding bound so SP never wraps.
module stack_ptr
  import mem_pkg::*;
#(
  parameter logic [15:0] SP_INIT  = SP_INIT_DEFAULT,
  parameter logic [15:0] SP_LIMIT = SP_LIMIT_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inc,
  input  logic        dec,
  output logic [15:0] sp,
  output logic        full,
  output logic        empty
);

  logic [15:0] r_sp;

  // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst)
      r_sp <= SP_INIT;
    else if (inc && !empty)
      r_sp <= r_sp + 16'd1;
    else if (dec && !full)
      r_sp <= r_sp - 16'd1;
  end

  assign sp    = r_sp;
  assign full  = (r_sp == SP_LIMIT);
  assign empty = (r_sp == SP_INIT);

endmodule

// File: rtl/mem_stack_ctrl.sv
// Memory-stage controller: LOAD/STORE plus hardware stack for PUSH/POP,
// CALL/RET and INT/RTI, with registered memory, writeback and redirect outputs.
module mem_stack_ctrl
  import mem_pkg::*;
#(
  parameter logic [15:0] SP_INIT  = SP_INIT_DEFAULT,
  parameter logic [15:0] SP_LIMIT = SP_LIMIT_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        op_valid,
  input  logic [3:0]  op_code,
  input  logic [15:0] op_addr,
  input  logic [15:0] op_data,
  input  logic [15:0] pc_next,
  input  logic [2:0]  flags_in,
  output logic        op_ready,
  output logic        stall,
  output logic        mem_re,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  output logic        wb_valid,
  output logic [15:0] wb_data,
  output logic        pc_load,
  output logic [15:0] pc_target,
  output logic        flags_load,
  output logic [2:0]  flags_out,
  output logic [15:0] sp_out,
  output logic        stack_err
);

  state_e      r_state;
  logic        r_mem_re, r_mem_we, r_wb_valid, r_pc_load, r_flags_load, r_stack_err;
  logic [15:0] r_mem_addr, r_mem_wdata, r_wb_data, r_pc_target, r_int_target;
  logic [2:0]  r_flags_out, r_int_flags;
  logic        r_rd_zero;

  op_e         w_op;
  logic        w_accept, w_push_req, w_pop_req, w_full, w_empty;
  logic [15:0] w_sp, w_push_data, w_rdata;

  assign w_op     = op_e'(op_code);
  assign w_accept = op_valid && (r_state == ST_IDLE);

  assign w_push_req = (w_accept && (w_op == OP_PUSH || w_op == OP_CALL || w_op == OP_INT))
                   || (r_state == ST_INT_FLAGS);
  assign w_pop_req  = (w_accept && (w_op == OP_POP || w_op == OP_RET || w_op == OP_RTI))
                   || (r_state == ST_RTI_PC);

  assign w_push_data = (r_state == ST_INT_FLAGS) ? {13'b0, r_int_flags}
                     : (w_op == OP_PUSH)         ? op_data : pc_next;

  // An underflowed pop issued no read, so its wait state sees zero instead of the bus.
  assign w_rdata = r_rd_zero ? 16'h0000 : mem_rdata;

  stack_ptr #(
    .SP_INIT  (SP_INIT),
    .SP_LIMIT (SP_LIMIT)
  ) u_stack_ptr (
    .clk   (clk),
    .rst   (rst),
    .inc   (w_pop_req),
    .dec   (w_push_req),
    .sp    (w_sp),
    .full  (w_full),
    .empty (w_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_mem_re     <= 1'b0;
      r_mem_we     <= 1'b0;
      r_wb_valid   <= 1'b0;
      r_pc_load    <= 1'b0;
      r_flags_load <= 1'b0;
      r_stack_err  <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_wb_data    <= '0;
      r_pc_target  <= '0;
      r_flags_out  <= '0;
      r_int_target <= '0;
      r_int_flags  <= '0;
      r_rd_zero    <= 1'b0;
    end else begin
      // NOTE: strobes default low each cycle; the branches below only raise them.
      r_mem_re     <= 1'b0;
      r_mem_we     <= 1'b0;
      r_wb_valid   <= 1'b0;
      r_pc_load    <= 1'b0;
      r_flags_load <= 1'b0;
      r_stack_err  <= 1'b0;

      if (w_push_req) begin
        r_mem_addr  <= w_sp - 16'd1;
        r_mem_wdata <= w_push_data;
        r_mem_we    <= !w_full;
        r_stack_err <= w_full;
      end
      if (w_pop_req) begin
        r_mem_addr  <= w_sp;
        r_mem_re    <= !w_empty;
        r_rd_zero   <= w_empty;
        r_stack_err <= w_empty;
      end

      case (r_state)
        ST_IDLE: begin
          if (op_valid) begin
            case (w_op)
              OP_LOAD: begin
                r_mem_re   <= 1'b1;
                r_mem_addr <= op_addr;
                r_rd_zero  <= 1'b0;
                r_state    <= ST_RD_WAIT;
              end
              OP_STORE: begin
                r_mem_we    <= 1'b1;
                r_mem_addr  <= op_addr;
                r_mem_wdata <= op_data;
              end
              OP_POP:  r_state <= ST_RD_WAIT;
              OP_CALL: begin
                r_pc_load   <= 1'b1;
                r_pc_target <= op_addr;
              end
              OP_RET:  r_state <= ST_RET_WAIT;
              OP_INT: begin
                r_int_flags  <= flags_in;
                r_int_target <= op_addr;
                r_state      <= ST_INT_FLAGS;
              end
              OP_RTI:  r_state <= ST_RTI_PC;
              default: ;
            endcase
          end
        end
        ST_RD_WAIT: begin
          r_wb_valid <= 1'b1;
          r_wb_data  <= w_rdata;
          r_state    <= ST_IDLE;
        end
        ST_RET_WAIT, ST_RTI_WAIT: begin
          r_pc_load   <= 1'b1;
          r_pc_target <= w_rdata;
          r_state     <= ST_IDLE;
        end
        ST_INT_FLAGS: begin
          r_pc_load   <= 1'b1;
          r_pc_target <= r_int_target;
          r_state     <= ST_IDLE;
        end
        ST_RTI_PC: begin
          r_flags_load <= 1'b1;
          r_flags_out  <= w_rdata[2:0];
          r_state      <= ST_RTI_WAIT;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign op_ready   = (r_state == ST_IDLE);
  assign stall      = !op_ready;
  assign mem_re     = r_mem_re;
  assign mem_we     = r_mem_we;
  assign mem_addr   = r_mem_addr;
  assign mem_wdata  = r_mem_wdata;
  assign wb_valid   = r_wb_valid;
  assign wb_data    = r_wb_data;
  assign pc_load    = r_pc_load;
  assign pc_target  = r_pc_target;
  assign flags_load = r_flags_load;
  assign flags_out  = r_flags_out;
  assign sp_out     = w_sp;
  assign stack_err  = r_stack_err;

endmodule
